cache_port_arbiter: RTL and testbench

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/cache_port_arbiter_if.sv | 28 ++
 rtl/rr_priority_picker.sv | 27 ++
 rtl/cache_port_arbiter.sv | 100 ++++++++++
 tb/tb_cache_port_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the cache port arbiter.
package mem_arb_pkg;
    typedef enum logic {S_IDLE, S_GRANT} arb_state_t;

    localparam int N_REQ_DEF      = 4;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int DWIDTH_DEF     = 16;
endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester and cache-side signal bundle; slave is the arbiter's view.
interface cache_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DWIDTH     = DWIDTH_DEF
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0]            resp_valid;
    logic [DWIDTH-1:0]           resp_data;
    logic                        mem_addr_valid;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic                        mem_addr_ready;
    logic [DWIDTH-1:0]           mem_data;

    modport slave (
        input  req_valid, req_addr, mem_addr_ready, mem_data,
        output req_ready, resp_valid, resp_data, mem_addr_valid, mem_addr
    );

    modport master (
        output req_valid, req_addr, mem_addr_ready, mem_data,
        input  req_ready, resp_valid, resp_data, mem_addr_valid, mem_addr
    );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping mod N_REQ.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    idx,
    output logic             any
);
    int j;

    // Scan from the farthest offset down so the nearest match wins last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[j[IW-1:0]]) begin
                idx = IW'(j);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache port among N_REQ requesters, one response slot.
module cache_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DWIDTH     = DWIDTH_DEF
) (
    input logic clk,
    input logic rst,
    cache_port_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    typedef logic [IW-1:0] idx_t;

    arb_state_t state, state_nx;
    idx_t rr_ptr, rr_nx, grant_id, grant_nx, resp_id, rid_nx, pick, grant_inc;
    logic resp_pend, pend_nx, any, gvalid;
    logic [N_REQ-1:0]      ready_c;
    logic                  mav_c;
    logic [ADDR_WIDTH-1:0] maddr_c;

    rr_priority_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .idx (pick),
        .any (any)
    );

    assign gvalid    = bus.req_valid[grant_id];
    assign grant_inc = (grant_id == idx_t'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            resp_pend <= 1'b0;
            resp_id   <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            grant_id  <= grant_nx;
            resp_pend <= pend_nx;
            resp_id   <= rid_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rr_nx    = rr_ptr;
        grant_nx = grant_id;
        pend_nx  = 1'b0;
        rid_nx   = resp_id;
        ready_c  = '0;
        mav_c    = 1'b0;
        maddr_c  = '0;
        case (state)
            S_IDLE: begin
                if (any) begin
                    grant_nx = pick;
                    state_nx = S_GRANT;
                end
            end
            S_GRANT: begin
                mav_c             = gvalid;
                maddr_c           = bus.req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
                ready_c[grant_id] = bus.mem_addr_ready && gvalid;
                if (gvalid && bus.mem_addr_ready) begin
                    rr_nx    = grant_inc;
                    pend_nx  = 1'b1;
                    rid_nx   = grant_id;
                    state_nx = S_IDLE;
                end else if (!gvalid) begin
                    // Requester withdrew: abandon the grant, keep fairness pointer.
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are forced low while rst is high, which also drops a pending response.
    always_comb begin
        bus.req_ready      = '0;
        bus.mem_addr_valid = 1'b0;
        bus.mem_addr       = '0;
        bus.resp_valid     = '0;
        bus.resp_data      = '0;
        if (!rst) begin
            bus.req_ready      = ready_c;
            bus.mem_addr_valid = mav_c;
            bus.mem_addr       = maddr_c;
            if (resp_pend) begin
                bus.resp_valid[resp_id] = 1'b1;
                bus.resp_data           = bus.mem_data;
            end
        end
    end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_cache_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk, rst, rst3;
    int total = 0;
    int bad   = 0;

    cache_port_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DWIDTH(DW)) bus ();
    cache_port_arbiter_if #(.N_REQ(3), .ADDR_WIDTH(AW), .DWIDTH(DW)) b3 ();

    cache_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DWIDTH(DW)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    cache_port_arbiter #(.N_REQ(3), .ADDR_WIDTH(AW), .DWIDTH(DW)) dut3 (
        .clk (clk), .rst (rst3), .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: current grant (-1 none), round-robin start, pending response (-1 none).
    int m_g = -1, m_ptr = 0, m_pend = -1;
    int n_g, n_ptr, n_pend;
    logic [N-1:0] acc;
    logic [N-1:0] vq;
    logic [AW-1:0] aq [N];

    function automatic int first_from(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic drive();
        bus.req_valid = vq;
        for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = aq[i];
    endtask

    task automatic sample();
        logic [N-1:0] v, e_rdy, e_rv;
        logic e_mav;
        logic [AW-1:0] e_ma;
        logic [DW-1:0] e_rd;
        #1;
        v = bus.req_valid;
        e_rdy = '0; e_rv = '0; e_mav = 1'b0; e_ma = '0; e_rd = '0;
        if (!rst) begin
            if (m_g >= 0) begin
                e_mav = v[m_g];
                e_ma  = bus.req_addr[m_g*AW +: AW];
                if (v[m_g] && bus.mem_addr_ready) e_rdy[m_g] = 1'b1;
            end
            if (m_pend >= 0) begin
                e_rv[m_pend] = 1'b1;
                e_rd = bus.mem_data;
            end
        end
        chk("req_ready", bus.req_ready, e_rdy);
        chk("mem_addr_valid", bus.mem_addr_valid, e_mav);
        chk("mem_addr", bus.mem_addr, e_ma);
        chk("resp_valid", bus.resp_valid, e_rv);
        chk("resp_data", bus.resp_data, e_rd);
        acc = e_rdy;
        n_g = m_g; n_ptr = m_ptr; n_pend = -1;
        if (rst) begin
            n_g = -1; n_ptr = 0;
        end else if (m_g < 0) begin
            n_g = first_from(m_ptr, v);
        end else if (v[m_g] && bus.mem_addr_ready) begin
            n_ptr = (m_g + 1) % N; n_pend = m_g; n_g = -1;
        end else if (!v[m_g]) begin
            n_g = -1;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        m_g = n_g; m_ptr = n_ptr; m_pend = n_pend;
        @(negedge clk);
    endtask

    task automatic set_v(input logic [N-1:0] v);
        vq = v;
        drive();
    endtask

    // N_REQ=3 instance: all requesters always valid, cache always ready.
    bit n3_done = 0;
    initial begin
        int cnt;
        int got [4];
        int exp3 [4];
        exp3 = '{0, 1, 2, 0};
        got  = '{-1, -1, -1, -1};
        rst3 = 1'b1;
        b3.req_valid = '1; b3.req_addr = '0; b3.mem_addr_ready = 1'b1; b3.mem_data = '0;
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        cnt = 0;
        for (int c = 0; c < 30 && cnt < 4; c++) begin
            @(negedge clk); #1;
            if (b3.req_ready != 0) begin
                for (int k = 0; k < 3; k++) if (b3.req_ready[k]) got[cnt] = k;
                cnt++;
            end
        end
        chk("n3_grant_count", cnt, 4);
        for (int k = 0; k < 4; k++) chk("n3_order", got[k], exp3[k]);
        n3_done = 1;
    end

    initial begin
        logic [N-1:0] ord;
        rst = 1'b1;
        vq = '0;
        for (int i = 0; i < N; i++) aq[i] = AW'(16'h0100 + i);
        drive();
        bus.mem_addr_ready = 1'b1;
        bus.mem_data = 16'hBEEF;
        @(negedge clk);

        // Outputs low during reset even with everyone requesting
        set_v(4'b1111);
        sample(); chk("rst_req_ready", bus.req_ready, 0); chk("rst_mav", bus.mem_addr_valid, 0);
        chk("rst_resp_valid", bus.resp_valid, 0); adv();
        sample(); chk("rst_mem_addr", bus.mem_addr, 0); chk("rst_resp_data", bus.resp_data, 0); adv();
        rst = 1'b0;

        // Single requester 2
        aq[2] = 16'h0042; set_v(4'b0100);
        sample(); chk("r2_T_ready", bus.req_ready, 0); chk("r2_T_mav", bus.mem_addr_valid, 0); adv();
        sample(); chk("r2_T1_ready", bus.req_ready, 4'b0100); chk("r2_T1_addr", bus.mem_addr, 16'h0042); adv();
        set_v(4'b0000);
        sample(); chk("r2_T2_rv", bus.resp_valid, 4'b0100); chk("r2_T2_data", bus.resp_data, 16'hBEEF); adv();

        // Pointer now 3: requesters 0 and 3 valid -> 3 first, then 0
        set_v(4'b1001);
        sample(); adv();
        sample(); chk("ptr3_first", bus.req_ready, 4'b1000); adv();
        set_v(4'b0001);
        sample(); chk("ptr3_resp", bus.resp_valid, 4'b1000); adv();
        sample(); chk("ptr3_second", bus.req_ready, 4'b0001); adv();
        set_v(4'b0000);
        sample(); adv();

        // Requester 1 stalled by the cache for 5 cycles, others pile up
        aq[1] = 16'h1234; set_v(4'b0010); bus.mem_addr_ready = 1'b0;
        sample(); adv();
        set_v(4'b1111);
        for (int k = 0; k < 5; k++) begin
            sample(); chk("stall_addr", bus.mem_addr, 16'h1234); chk("stall_ready", bus.req_ready, 0); adv();
        end
        bus.mem_addr_ready = 1'b1;
        sample(); chk("stall_accept", bus.req_ready, 4'b0010); adv();

        // Reset right after acceptance drops the response, restarts from 0
        rst = 1'b1;
        sample(); chk("rst_drop_rv", bus.resp_valid, 0); chk("rst_drop_data", bus.resp_data, 0); adv();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample(); chk("rr_idle_gap", bus.req_ready, 0); adv();
            ord = '0; ord[k % N] = 1'b1;
            sample(); chk("rr_order", bus.req_ready, ord); adv();
        end
        set_v(4'b0000);
        sample(); adv();

        // Random traffic with occasional withdrawals, stalls and resets
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 250) == 0;
            for (int i = 0; i < N; i++) begin
                if (vq[i]) begin
                    if (acc[i] || ($urandom % 40) == 0) vq[i] = 1'b0;
                end else if ($urandom % 2) begin
                    vq[i] = 1'b1;
                    aq[i] = AW'($urandom);
                end
            end
            bus.mem_addr_ready = ($urandom % 4) != 0;
            bus.mem_data = DW'($urandom);
            drive();
            sample();
            adv();
        end
        rst = 1'b0;

        chk("n3_done", n3_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
